// File: rtl/inv_sub_bytes_seq_pkg.sv
// aes_pkg: FSM state encoding, byte width and the AES S-box tables shared by
// inv_sub_bytes_seq and its inv_sbox lanes. The forward table is only
// referenced when INV_SUB_BYTES_FWD_EN is defined.
package aes_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_DRAIN = 2'd2,
      ST_DONE  = 2'd3
   } state_e;

   // Flat tables: entry 0x00 sits in the most significant byte.
   localparam logic [2047:0] INV_SBOX = {
      128'h52096ad53036a538bf40a39e81f3d7fb, 128'h7ce339829b2fff87348e4344c4dee9cb,
      128'h547b9432a6c2233dee4c950b42fac34e, 128'h082ea16628d924b2765ba2496d8bd125,
      128'h72f8f66486689816d4a45ccc5d65b692, 128'h6c704850fdedb9da5e154657a78d9d84,
      128'h90d8ab008cbcd30af7e45805b8b34506, 128'hd02c1e8fca3f0f02c1afbd0301138a6b,
      128'h3a9111414f67dcea97f2cfcef0b4e673, 128'h96ac7422e7ad3585e2f937e81c75df6e,
      128'h47f11a711d29c5896fb7620eaa18be1b, 128'hfc563e4bc6d279209adbc0fe78cd5af4,
      128'h1fdda8338807c731b11210592780ec5f, 128'h60517fa919b54a0d2de57a9f93c99cef,
      128'ha0e03b4dae2af5b0c8ebbb3c83539961, 128'h172b047eba77d626e169146355210c7d
   };

   localparam logic [2047:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   // Entry idx lives at bit offset (255-idx)*8, and 255-idx == ~idx for a byte.
   function automatic logic [7:0] inv_sbox_lu(input logic [7:0] idx);
      return INV_SBOX[{~idx, 3'b000} +: 8];
   endfunction

   function automatic logic [7:0] sbox_lu(input logic [7:0] idx);
      return SBOX[{~idx, 3'b000} +: 8];
   endfunction

endpackage

// File: rtl/inv_sub_bytes_seq_sbox.sv
// inv_sbox: one registered S-box lane (1-cycle lookup latency).
// With INV_SUB_BYTES_FWD_EN defined a fwd select picks the forward table.
module inv_sbox
   import aes_pkg::*;
(
   input  logic       clk,
`ifdef INV_SUB_BYTES_FWD_EN
   input  logic       fwd,
`endif
   input  logic [7:0] in,
   output logic [7:0] out
);

   logic [7:0] out_q;

   // Registered table lookup; pure datapath, so no reset.
   always_ff @(posedge clk) begin
`ifdef INV_SUB_BYTES_FWD_EN
      out_q <= fwd ? sbox_lu(in) : inv_sbox_lu(in);
`else
      out_q <= inv_sbox_lu(in);
`endif
   end

   assign out = out_q;

endmodule

// File: rtl/inv_sub_bytes_seq.sv
// inv_sub_bytes_seq: applies InvSubBytes to an NWords*32-bit state, LANES bytes
// per cycle through registered inv_sbox lanes, valid/ready on both sides.
// Optional macro INV_SUB_BYTES_FWD_EN adds a fwd input selecting the forward
// S-box, so the same unit can serve the encrypt path.
module inv_sub_bytes_seq
   import aes_pkg::*;
#(
   parameter int NWords = 4,
   parameter int LANES  = 4
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 in_valid,
   output logic                 in_ready,
`ifdef INV_SUB_BYTES_FWD_EN
   input  logic                 fwd,
`endif
   input  logic [NWords*32-1:0] bytes_in,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [NWords*32-1:0] bytes_out
);

   localparam int NBYTES  = 4 * NWords;
   localparam int NCHUNK  = NBYTES / LANES;
   localparam int CHUNK_W = LANES * BYTE_W;
   localparam int CNT_W   = $clog2(NCHUNK) + 1;
   localparam int IDX_W   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
   localparam logic [CNT_W-1:0] LAST_CHUNK = CNT_W'(NCHUNK - 1);

   if ((LANES < 1) || (NBYTES % LANES != 0)) begin : g_bad_lanes
      $error("inv_sub_bytes_seq: LANES must divide 4*NWords");
   end

   state_e                          state_q, state_d;
   logic [CNT_W-1:0]                cnt_q, cnt_d;
   logic [NCHUNK-1:0][CHUNK_W-1:0]  data_q, data_d;
   logic [NCHUNK-1:0][CHUNK_W-1:0]  out_q, out_d;
   logic                            wb_vld_q, wb_vld_d;
   logic [IDX_W-1:0]                wb_idx_q, wb_idx_d;
   logic [IDX_W-1:0]                issue_idx;
   logic [CHUNK_W-1:0]              lane_in;
   logic [CHUNK_W-1:0]              lane_out;
`ifdef INV_SUB_BYTES_FWD_EN
   logic                            fwd_q, fwd_d;
`endif

   // Lane mux: the chunk selected by the counter feeds all lanes.
   assign issue_idx = cnt_q[IDX_W-1:0];
   assign lane_in   = data_q[issue_idx];

   for (genvar l = 0; l < LANES; l++) begin : g_lane
      inv_sbox u_sbox (
         .clk (clk),
`ifdef INV_SUB_BYTES_FWD_EN
         .fwd (fwd_q),
`endif
         .in  (lane_in[l*BYTE_W +: BYTE_W]),
         .out (lane_out[l*BYTE_W +: BYTE_W])
      );
   end

   // Next-state, counter, input latch and write-back demux.
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      data_d    = data_q;
      out_d     = out_q;
      wb_vld_d  = 1'b0;
      wb_idx_d  = wb_idx_q;
      in_ready  = 1'b0;
      out_valid = 1'b0;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_d     = fwd_q;
`endif

      // A lookup issued last cycle lands at its own chunk position.
      if (wb_vld_q) begin
         out_d[wb_idx_q] = lane_out;
      end

      case (state_q)
         ST_IDLE: begin
            in_ready = 1'b1;
            cnt_d    = '0;
            if (in_valid) begin
               data_d  = bytes_in;
`ifdef INV_SUB_BYTES_FWD_EN
               fwd_d   = fwd;
`endif
               state_d = ST_RUN;
            end
         end
         ST_RUN: begin
            wb_vld_d = 1'b1;
            wb_idx_d = issue_idx;
            cnt_d    = cnt_q + 1'b1;
            if (cnt_q == LAST_CHUNK) begin
               state_d = ST_DRAIN;
            end
         end
         ST_DRAIN: begin
            state_d = ST_DONE;
         end
         ST_DONE: begin
            out_valid = 1'b1;
            if (out_ready) begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Control state and the presented result; reset drops any partial work.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q  <= ST_IDLE;
         cnt_q    <= '0;
         wb_vld_q <= 1'b0;
         out_q    <= '0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         wb_vld_q <= wb_vld_d;
         out_q    <= out_d;
      end
   end

   // Input latch and write-back index; only meaningful under the control above.
   always_ff @(posedge clk) begin
      data_q   <= data_d;
      wb_idx_q <= wb_idx_d;
`ifdef INV_SUB_BYTES_FWD_EN
      fwd_q    <= fwd_d;
`endif
   end

   assign bytes_out = out_q;

endmodule

// File: tb/tb_inv_sub_bytes_seq.sv
// Directed bench for inv_sub_bytes_seq: default build plus LANES=16 and LANES=1 instances.
module tb_inv_sub_bytes_seq;

   localparam int W = 128;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid;
   logic         out_ready;
   logic         fwd;
   logic [W-1:0] bytes_in;

   logic         in_ready4, out_valid4;
   logic [W-1:0] bytes_out4;
   logic         in_ready16, out_valid16;
   logic [W-1:0] bytes_out16;
   logic         in_ready1, out_valid1;
   logic [W-1:0] bytes_out1;

   int checks   = 0;
   int failures = 0;

   typedef struct {
      logic [W-1:0] din;
      logic [W-1:0] exp;
   } vec_t;

   vec_t vecs[5];

   always #5 clk = ~clk;

   inv_sub_bytes_seq #(.NWords(4), .LANES(4)) u_dut4 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready4),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd(fwd),
`endif
      .bytes_in(bytes_in), .out_valid(out_valid4), .out_ready(out_ready), .bytes_out(bytes_out4)
   );

   inv_sub_bytes_seq #(.NWords(4), .LANES(16)) u_dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready16),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd(fwd),
`endif
      .bytes_in(bytes_in), .out_valid(out_valid16), .out_ready(out_ready), .bytes_out(bytes_out16)
   );

   inv_sub_bytes_seq #(.NWords(4), .LANES(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
`ifdef INV_SUB_BYTES_FWD_EN
      .fwd(fwd),
`endif
      .bytes_in(bytes_in), .out_valid(out_valid1), .out_ready(out_ready), .bytes_out(bytes_out1)
   );

   task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got %h, want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one state to the LANES=4 instance and return right after the accepting edge.
   task automatic accept(input logic [W-1:0] din, input string name);
      int waited;
      waited = 0;
      while (!in_ready4 && waited < 100) begin
         tick();
         waited++;
      end
      check($sformatf("%s in_ready before send", name), W'(in_ready4), W'(1));
      in_valid = 1'b1;
      bytes_in = din;
      tick();
      in_valid = 1'b0;
   endtask

   // Edges counted from the accepting edge until out_valid is seen (bounded).
   task automatic wait_out(output int lat);
      lat = 0;
      while (!out_valid4 && lat < 50) begin
         tick();
         lat++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int lat;
      int lat4, lat16, lat1;
      logic stable;
      logic [W-1:0] d4, d16, d1;

      vecs[0] = '{din: {16{8'h63}},       exp: '0};
      vecs[1] = '{din: {4{32'h1600ed7c}}, exp: {4{32'hff525301}}};
      vecs[2] = '{din: 128'h76abd7fe2b670130c56f6bf27b777c63,
                  exp: 128'h0f0e0d0c0b0a09080706050403020100};
      vecs[3] = '{din: 128'hc072a49cafa2d4adf04759fa7dc982ca,
                  exp: 128'h1f1e1d1c1b1a19181716151413121110};
      vecs[4] = '{din: 128'h16bb54b00f2d99416842e6bf0d89a18c,
                  exp: 128'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0};

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      out_ready = 1'b1;
      fwd       = 1'b0;
      bytes_in  = '0;
      tick();
      tick();
      check("reset in_ready", W'(in_ready4), W'(1));
      check("reset out_valid", W'(out_valid4), W'(0));
      check("reset bytes_out", bytes_out4, '0);
      rst_n = 1'b1;
      tick();

      // Table-driven vectors through the default build.
      for (int i = 0; i < 5; i++) begin
         accept(vecs[i].din, $sformatf("vec%0d", i));
         check($sformatf("vec%0d in_ready busy", i), W'(in_ready4), W'(0));
         wait_out(lat);
         check($sformatf("vec%0d latency", i), W'(lat), W'(5));
         check($sformatf("vec%0d data", i), bytes_out4, vecs[i].exp);
         tick();
         check($sformatf("vec%0d out_valid after xfer", i), W'(out_valid4), W'(0));
         check($sformatf("vec%0d in_ready after xfer", i), W'(in_ready4), W'(1));
      end

      // Backpressure: hold DONE for 10 cycles while offering a competing input.
      out_ready = 1'b0;
      accept(vecs[1].din, "hold");
      wait_out(lat);
      check("hold latency", W'(lat), W'(5));
      stable = 1'b1;
      for (int c = 0; c < 10; c++) begin
         in_valid = 1'b1;
         bytes_in = vecs[0].din;
         tick();
         if (bytes_out4 !== vecs[1].exp || in_ready4 !== 1'b0 || out_valid4 !== 1'b1) stable = 1'b0;
      end
      check("hold stable", W'(stable), W'(1));
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("hold release out_valid", W'(out_valid4), W'(0));
      check("hold release in_ready", W'(in_ready4), W'(1));
      check("hold bytes_out kept", bytes_out4, vecs[1].exp);
      tick();
      check("hold single transfer", W'(out_valid4), W'(0));

      // Reset after two chunks have been issued.
      accept(vecs[2].din, "midrst");
      tick();
      tick();
      rst_n = 1'b0;
      tick();
      check("midrst out_valid", W'(out_valid4), W'(0));
      check("midrst bytes_out", bytes_out4, '0);
      check("midrst in_ready", W'(in_ready4), W'(1));
      rst_n = 1'b1;
      stable = 1'b1;
      for (int c = 0; c < 6; c++) begin
         tick();
         if (out_valid4 !== 1'b0 || bytes_out4 !== '0) stable = 1'b0;
      end
      check("midrst no partial result", W'(stable), W'(1));
      accept(vecs[3].din, "postrst");
      wait_out(lat);
      check("postrst latency", W'(lat), W'(5));
      check("postrst data", bytes_out4, vecs[3].exp);
      tick();

      // LANES=16 and LANES=1 builds side by side with the default one.
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      in_valid = 1'b1;
      bytes_in = vecs[4].din;
      tick();
      in_valid = 1'b0;
      check("lanes16 in_ready busy", W'(in_ready16), W'(0));
      check("lanes1 in_ready busy", W'(in_ready1), W'(0));
      lat4 = -1; lat16 = -1; lat1 = -1;
      d4 = '0; d16 = '0; d1 = '0;
      for (int c = 1; c <= 40; c++) begin
         tick();
         if (out_valid4 && lat4 < 0) begin lat4 = c; d4 = bytes_out4; end
         if (out_valid16 && lat16 < 0) begin lat16 = c; d16 = bytes_out16; end
         if (out_valid1 && lat1 < 0) begin lat1 = c; d1 = bytes_out1; end
      end
      check("lanes4 latency", W'(lat4), W'(5));
      check("lanes16 latency", W'(lat16), W'(2));
      check("lanes1 latency", W'(lat1), W'(17));
      check("lanes4 data", d4, vecs[4].exp);
      check("lanes16 data", d16, vecs[4].exp);
      check("lanes1 data", d1, vecs[4].exp);

`ifdef INV_SUB_BYTES_FWD_EN
      // Shared forward/inverse unit.
      fwd = 1'b1;
      accept({16{8'h53}}, "fwd1");
      fwd = 1'b0;
      wait_out(lat);
      check("fwd1 latency", W'(lat), W'(5));
      check("fwd1 data", bytes_out4, {16{8'hed}});
      tick();
      accept({16{8'hed}}, "fwd0");
      wait_out(lat);
      check("fwd0 latency", W'(lat), W'(5));
      check("fwd0 data", bytes_out4, {16{8'h53}});
      tick();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
